// File: rtl/tl_link_pkg.sv
// Shared TileLink-UL field widths, opcode constants and packed channel
// structs for the link buffer and its FIFOs.
package tl_link_pkg;

   localparam int OPCODE_W  = 3;
   localparam int SOURCE_W  = 3;
   localparam int SIZE_W    = 2;
   localparam int ADDR_W    = 30;
   localparam int DATA_W    = 32;
   localparam int MASK_W    = 4;
   localparam int A_PARAM_W = 3;
   localparam int D_PARAM_W = 2;

   localparam logic [OPCODE_W-1:0] OP_GET             = 3'd4;
   localparam logic [OPCODE_W-1:0] OP_PUT_FULL        = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_PUT_PARTIAL     = 3'd1;
   localparam logic [OPCODE_W-1:0] OP_ACCESS_ACK      = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_ACCESS_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [A_PARAM_W-1:0] param;
      logic [SIZE_W-1:0]    size;
      logic [SOURCE_W-1:0]  source;
      logic [ADDR_W-1:0]    address;
      logic [MASK_W-1:0]    mask;
      logic [DATA_W-1:0]    data;
   } tl_a_t;

   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [D_PARAM_W-1:0] param;
      logic [SIZE_W-1:0]    size;
      logic [SOURCE_W-1:0]  source;
      logic                 denied;
      logic                 corrupt;
      logic [DATA_W-1:0]    data;
   } tl_d_t;

endpackage

// File: rtl/tl_link_fifo.sv
// Occupancy-counted FIFO for one TL-UL channel; FLOW lets an empty FIFO
// present the incoming beat combinationally and skip storing it if taken.
module tl_link_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter bit FLOW  = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             in_en,
   input  logic [WIDTH-1:0] in_data,
   output logic             full,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             empty;
   logic             bypass;
   logic             push;
   logic             pop;

   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_W'(DEPTH));

   // Bypass only when the producer will actually fire, so a taken bypass beat
   // can never be presented without the matching upstream handshake.
   assign bypass    = FLOW && empty && in_valid && in_en;
   assign out_valid = !empty || bypass;
   assign out_data  = bypass ? in_data : mem[rd_ptr];

   assign push = in_valid && in_en && !(bypass && out_ready);
   assign pop  = out_ready && !empty;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/tl_ul_link_buffer.sv
// Registered TL-UL buffer with separate A/D FIFOs and an in-flight request cap.
// Define TL_LINK_BUF_FLOW_EN for zero-latency A pass-through when the A FIFO is empty.
module tl_ul_link_buffer
   import tl_link_pkg::*;
#(
   parameter int A_DEPTH      = 2,
   parameter int D_DEPTH      = 2,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 a_in_valid,
   output logic                 a_in_ready,
   input  logic [OPCODE_W-1:0]  a_in_opcode,
   input  logic [A_PARAM_W-1:0] a_in_param,
   input  logic [SIZE_W-1:0]    a_in_size,
   input  logic [SOURCE_W-1:0]  a_in_source,
   input  logic [ADDR_W-1:0]    a_in_address,
   input  logic [MASK_W-1:0]    a_in_mask,
   input  logic [DATA_W-1:0]    a_in_data,
   output logic                 a_out_valid,
   input  logic                 a_out_ready,
   output logic [OPCODE_W-1:0]  a_out_opcode,
   output logic [A_PARAM_W-1:0] a_out_param,
   output logic [SIZE_W-1:0]    a_out_size,
   output logic [SOURCE_W-1:0]  a_out_source,
   output logic [ADDR_W-1:0]    a_out_address,
   output logic [MASK_W-1:0]    a_out_mask,
   output logic [DATA_W-1:0]    a_out_data,
   input  logic                 d_in_valid,
   output logic                 d_in_ready,
   input  logic [OPCODE_W-1:0]  d_in_opcode,
   input  logic [D_PARAM_W-1:0] d_in_param,
   input  logic [SIZE_W-1:0]    d_in_size,
   input  logic [SOURCE_W-1:0]  d_in_source,
   input  logic                 d_in_denied,
   input  logic                 d_in_corrupt,
   input  logic [DATA_W-1:0]    d_in_data,
   output logic                 d_out_valid,
   input  logic                 d_out_ready,
   output logic [OPCODE_W-1:0]  d_out_opcode,
   output logic [D_PARAM_W-1:0] d_out_param,
   output logic [SIZE_W-1:0]    d_out_size,
   output logic [SOURCE_W-1:0]  d_out_source,
   output logic                 d_out_denied,
   output logic                 d_out_corrupt,
   output logic [DATA_W-1:0]    d_out_data,
   output logic [3:0]           inflight,
   output logic                 protocol_err
);

`ifdef TL_LINK_BUF_FLOW_EN
   localparam bit A_FLOW = 1'b1;
`else
   localparam bit A_FLOW = 1'b0;
`endif

   tl_a_t      a_in_s;
   tl_a_t      a_out_s;
   tl_d_t      d_in_s;
   tl_d_t      d_out_s;
   logic       a_full;
   logic       d_full;
   logic       rdy_en_q;
   logic [3:0] inflight_q;
   logic       err_q;
   logic       a_in_fire;
   logic       d_out_fire;

   assign a_in_s = '{opcode: a_in_opcode, param: a_in_param, size: a_in_size,
                     source: a_in_source, address: a_in_address, mask: a_in_mask,
                     data: a_in_data};
   assign d_in_s = '{opcode: d_in_opcode, param: d_in_param, size: d_in_size,
                     source: d_in_source, denied: d_in_denied, corrupt: d_in_corrupt,
                     data: d_in_data};

   // Readies are held low until the first edge after reset release.
   assign a_in_ready = rdy_en_q && !a_full && (inflight_q < 4'(MAX_INFLIGHT));
   assign d_in_ready = rdy_en_q && !d_full;

   assign a_in_fire  = a_in_valid && a_in_ready;
   assign d_out_fire = d_out_valid && d_out_ready;

   tl_link_fifo #(.WIDTH($bits(tl_a_t)), .DEPTH(A_DEPTH), .FLOW(A_FLOW)) u_a_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (a_in_valid),
      .in_en     (a_in_ready),
      .in_data   (a_in_s),
      .full      (a_full),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_s)
   );

   tl_link_fifo #(.WIDTH($bits(tl_d_t)), .DEPTH(D_DEPTH), .FLOW(1'b0)) u_d_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (d_in_valid),
      .in_en     (d_in_ready),
      .in_data   (d_in_s),
      .full      (d_full),
      .out_valid (d_out_valid),
      .out_ready (d_out_ready),
      .out_data  (d_out_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdy_en_q   <= 1'b0;
         inflight_q <= 4'd0;
         err_q      <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         if (d_out_fire && inflight_q == 4'd0) err_q <= 1'b1;
         if (a_in_fire && !d_out_fire)
            inflight_q <= inflight_q + 4'd1;
         else if (!a_in_fire && d_out_fire && inflight_q != 4'd0)
            inflight_q <= inflight_q - 4'd1;
      end
   end

   assign inflight     = inflight_q;
   assign protocol_err = err_q;

   assign a_out_opcode  = a_out_s.opcode;
   assign a_out_param   = a_out_s.param;
   assign a_out_size    = a_out_s.size;
   assign a_out_source  = a_out_s.source;
   assign a_out_address = a_out_s.address;
   assign a_out_mask    = a_out_s.mask;
   assign a_out_data    = a_out_s.data;

   assign d_out_opcode  = d_out_s.opcode;
   assign d_out_param   = d_out_s.param;
   assign d_out_size    = d_out_s.size;
   assign d_out_source  = d_out_s.source;
   assign d_out_denied  = d_out_s.denied;
   assign d_out_corrupt = d_out_s.corrupt;
   assign d_out_data    = d_out_s.data;

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Directed bench for tl_ul_link_buffer: request/response, in-flight cap,
// backpressure with pointer wrap, spurious response, mid-burst reset, flow mode.
module tb_tl_ul_link_buffer;
   import tl_link_pkg::*;

   logic                 clock = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 a_in_valid = 1'b0;
   logic                 a_in_ready;
   logic [OPCODE_W-1:0]  a_in_opcode = '0;
   logic [A_PARAM_W-1:0] a_in_param = '0;
   logic [SIZE_W-1:0]    a_in_size = '0;
   logic [SOURCE_W-1:0]  a_in_source = '0;
   logic [ADDR_W-1:0]    a_in_address = '0;
   logic [MASK_W-1:0]    a_in_mask = '0;
   logic [DATA_W-1:0]    a_in_data = '0;
   logic                 a_out_valid;
   logic                 a_out_ready = 1'b0;
   logic [OPCODE_W-1:0]  a_out_opcode;
   logic [A_PARAM_W-1:0] a_out_param;
   logic [SIZE_W-1:0]    a_out_size;
   logic [SOURCE_W-1:0]  a_out_source;
   logic [ADDR_W-1:0]    a_out_address;
   logic [MASK_W-1:0]    a_out_mask;
   logic [DATA_W-1:0]    a_out_data;
   logic                 d_in_valid = 1'b0;
   logic                 d_in_ready;
   logic [OPCODE_W-1:0]  d_in_opcode = '0;
   logic [D_PARAM_W-1:0] d_in_param = '0;
   logic [SIZE_W-1:0]    d_in_size = '0;
   logic [SOURCE_W-1:0]  d_in_source = '0;
   logic                 d_in_denied = 1'b0;
   logic                 d_in_corrupt = 1'b0;
   logic [DATA_W-1:0]    d_in_data = '0;
   logic                 d_out_valid;
   logic                 d_out_ready = 1'b0;
   logic [OPCODE_W-1:0]  d_out_opcode;
   logic [D_PARAM_W-1:0] d_out_param;
   logic [SIZE_W-1:0]    d_out_size;
   logic [SOURCE_W-1:0]  d_out_source;
   logic                 d_out_denied;
   logic                 d_out_corrupt;
   logic [DATA_W-1:0]    d_out_data;
   logic [3:0]           inflight;
   logic                 protocol_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   tl_ul_link_buffer #(.A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(4)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .a_in_valid    (a_in_valid),
      .a_in_ready    (a_in_ready),
      .a_in_opcode   (a_in_opcode),
      .a_in_param    (a_in_param),
      .a_in_size     (a_in_size),
      .a_in_source   (a_in_source),
      .a_in_address  (a_in_address),
      .a_in_mask     (a_in_mask),
      .a_in_data     (a_in_data),
      .a_out_valid   (a_out_valid),
      .a_out_ready   (a_out_ready),
      .a_out_opcode  (a_out_opcode),
      .a_out_param   (a_out_param),
      .a_out_size    (a_out_size),
      .a_out_source  (a_out_source),
      .a_out_address (a_out_address),
      .a_out_mask    (a_out_mask),
      .a_out_data    (a_out_data),
      .d_in_valid    (d_in_valid),
      .d_in_ready    (d_in_ready),
      .d_in_opcode   (d_in_opcode),
      .d_in_param    (d_in_param),
      .d_in_size     (d_in_size),
      .d_in_source   (d_in_source),
      .d_in_denied   (d_in_denied),
      .d_in_corrupt  (d_in_corrupt),
      .d_in_data     (d_in_data),
      .d_out_valid   (d_out_valid),
      .d_out_ready   (d_out_ready),
      .d_out_opcode  (d_out_opcode),
      .d_out_param   (d_out_param),
      .d_out_size    (d_out_size),
      .d_out_source  (d_out_source),
      .d_out_denied  (d_out_denied),
      .d_out_corrupt (d_out_corrupt),
      .d_out_data    (d_out_data),
      .inflight      (inflight),
      .protocol_err  (protocol_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // n responses with the upstream D consumer always ready, then let them drain
   task automatic send_d(input int n, input logic [31:0] data);
      d_out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         d_in_valid  = 1'b1;
         d_in_opcode = OP_ACCESS_ACK_DATA;
         d_in_data   = data + 32'(i);
         tick();
      end
      d_in_valid = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int deq_idx;
      int next_enq;

      // reset state
      repeat (2) tick();
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_d_in_ready", d_in_ready, 0);
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_d_out_valid", d_out_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_protocol_err", protocol_err, 0);
      reset_n = 1'b1;
      #1 chk("rel_ready_before_edge", a_in_ready, 0);
      tick();
      chk("rel_a_in_ready", a_in_ready, 1);
      chk("rel_d_in_ready", d_in_ready, 1);

      // single Get and its AccessAckData
      a_out_ready  = 1'b1;
      a_in_valid   = 1'b1;
      a_in_opcode  = OP_GET;
      a_in_source  = 3'd5;
      a_in_address = 30'h1000;
      a_in_mask    = 4'hf;
      a_in_size    = 2'd2;
`ifndef TL_LINK_BUF_FLOW_EN
      #1 chk("single_latency", a_out_valid, 0);
`endif
      tick();
      a_in_valid = 1'b0;
`ifndef TL_LINK_BUF_FLOW_EN
      chk("single_a_out_valid", a_out_valid, 1);
      chk("single_a_opcode", a_out_opcode, 4);
      chk("single_a_source", a_out_source, 5);
      chk("single_a_address", a_out_address, 30'h1000);
      chk("single_a_mask", a_out_mask, 4'hf);
`endif
      chk("single_inflight_1", inflight, 1);
      tick();
      chk("single_a_drained", a_out_valid, 0);
      d_out_ready = 1'b1;
      d_in_valid  = 1'b1;
      d_in_opcode = OP_ACCESS_ACK_DATA;
      d_in_source = 3'd5;
      d_in_size   = 2'd2;
      d_in_data   = 32'hDEADBEEF;
      #1 chk("single_d_latency", d_out_valid, 0);
      tick();
      d_in_valid = 1'b0;
      chk("single_d_out_valid", d_out_valid, 1);
      chk("single_d_data", d_out_data, 32'hDEADBEEF);
      chk("single_d_opcode", d_out_opcode, 1);
      chk("single_d_source", d_out_source, 5);
      tick();
      chk("single_inflight_0", inflight, 0);
      chk("single_d_drained", d_out_valid, 0);
      chk("single_no_err", protocol_err, 0);

      // in-flight cap with D side stalled
      d_out_ready = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("cap_ready_before", a_in_ready, 1);
         a_in_valid   = 1'b1;
         a_in_address = 30'h2000 + 30'(i);
         tick();
      end
      a_in_valid = 1'b0;
      chk("cap_ready_dropped", a_in_ready, 0);
      chk("cap_inflight_4", inflight, 4);
      tick();
      chk("cap_ready_held", a_in_ready, 0);
      d_in_valid = 1'b1;
      d_in_data  = 32'h0000_00A0;
      tick();
      d_in_valid = 1'b0;
      chk("cap_d_out_valid", d_out_valid, 1);
      d_out_ready = 1'b1;
      #1 chk("cap_no_comb_path", a_in_ready, 0);
      tick();
      chk("cap_inflight_3", inflight, 3);
      chk("cap_ready_back", a_in_ready, 1);
      send_d(3, 32'h0000_00B0);
      chk("cap_inflight_clear", inflight, 0);

      // backpressure to full, then alternating enqueue/dequeue across wrap
      a_out_ready  = 1'b0;
      a_in_valid   = 1'b1;
      a_in_address = 30'h100;
      tick();
      a_in_address = 30'h101;
      tick();
      a_in_valid = 1'b0;
      chk("bp_full_ready", a_in_ready, 0);
      chk("bp_inflight_2", inflight, 2);
      send_d(2, 32'h0000_00C0);
      chk("bp_inflight_0", inflight, 0);
      deq_idx  = 0;
      next_enq = 2;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            chk("bp_deq_ready", a_in_ready, 0);
            chk("bp_deq_valid", a_out_valid, 1);
            chk("bp_deq_addr", a_out_address, 30'h100 + 30'(deq_idx));
            deq_idx++;
            a_out_ready = 1'b1;
            a_in_valid  = 1'b0;
         end else begin
            chk("bp_enq_ready", a_in_ready, 1);
            chk("bp_enq_valid", a_out_valid, 1);
            a_out_ready  = 1'b0;
            a_in_valid   = 1'b1;
            a_in_address = 30'h100 + 30'(next_enq);
            next_enq++;
         end
         tick();
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      chk("bp_drain_a3", a_out_address, 30'h103);
      tick();
      chk("bp_drain_a4", a_out_address, 30'h104);
      tick();
      chk("bp_drained", a_out_valid, 0);
      send_d(3, 32'h0000_00D0);
      chk("bp_inflight_clear", inflight, 0);

      // spurious response
      d_out_ready = 1'b1;
      d_in_valid  = 1'b1;
      d_in_opcode = OP_ACCESS_ACK;
      d_in_source = 3'd2;
      d_in_data   = 32'h1234_5678;
      tick();
      d_in_valid = 1'b0;
      chk("spur_delivered", d_out_valid, 1);
      chk("spur_data", d_out_data, 32'h1234_5678);
      chk("spur_err_before", protocol_err, 0);
      tick();
      chk("spur_err_set", protocol_err, 1);
      chk("spur_inflight", inflight, 0);
      repeat (3) tick();
      chk("spur_err_sticky", protocol_err, 1);

      // reset in the middle of a burst
      a_out_ready  = 1'b0;
      a_in_valid   = 1'b1;
      a_in_address = 30'h200;
      tick();
      a_in_address = 30'h201;
      tick();
      a_in_valid = 1'b0;
      chk("mrst_queued", a_out_valid, 1);
      chk("mrst_inflight_2", inflight, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_a_out_valid", a_out_valid, 0);
      chk("mrst_a_in_ready", a_in_ready, 0);
      chk("mrst_d_in_ready", d_in_ready, 0);
      chk("mrst_inflight", inflight, 0);
      chk("mrst_err", protocol_err, 0);
      tick();
      reset_n = 1'b1;
      #1 chk("mrst_ready_low", a_in_ready, 0);
      tick();
      chk("mrst_a_in_ready_1", a_in_ready, 1);
      chk("mrst_d_in_ready_1", d_in_ready, 1);
      chk("mrst_empty", a_out_valid, 0);
      chk("mrst_inflight_0", inflight, 0);
      chk("mrst_err_clear", protocol_err, 0);
      a_out_ready = 1'b1;
      tick();
      chk("mrst_no_partial_a", a_out_valid, 0);
      chk("mrst_no_partial_d", d_out_valid, 0);

`ifdef TL_LINK_BUF_FLOW_EN
      // zero-latency pass-through on an empty A FIFO
      a_out_ready  = 1'b1;
      a_in_valid   = 1'b1;
      a_in_opcode  = OP_PUT_FULL;
      a_in_source  = 3'd3;
      a_in_address = 30'h3ABC;
      a_in_data    = 32'hCAFE_F00D;
      #1;
      chk("flow_valid", a_out_valid, 1);
      chk("flow_address", a_out_address, 30'h3ABC);
      chk("flow_data", a_out_data, 32'hCAFE_F00D);
      chk("flow_source", a_out_source, 3);
      tick();
      a_in_valid = 1'b0;
      #1 chk("flow_not_stored", a_out_valid, 0);
      chk("flow_inflight", inflight, 1);
      send_d(1, 32'h0000_00E0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_ul_link_buffer.md
# tl_ul_link_buffer

Registered TileLink-UL buffer stage on one 32-bit master port. It sits directly upstream of the A/D pass-through crossbar port and feeds that port's A-channel inputs. It also consumes the D-channel outputs from that port. It holds A requests and D responses in separate FIFOs, and it caps the number of in-flight requests so the downstream slave never sees more than MAX_INFLIGHT outstanding transactions.

## Interface
Parameters:
- A_DEPTH, 2: A-channel FIFO entries; power of two, ≥2.
- D_DEPTH, 2: D-channel FIFO entries; power of two, ≥2.
- MAX_INFLIGHT, 4: maximum accepted-but-unanswered requests; 1..15.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- a_in_valid / a_in_ready  in/out  1/1  upstream A handshake.
- a_in_opcode, a_in_param, a_in_size, a_in_source  in  3/3/2/3  A control fields.
- a_in_address, a_in_mask, a_in_data  in  30/4/32  A payload.
- a_out_valid / a_out_ready  out/in  1/1  downstream A handshake.
- a_out_*  out  same widths as a_in_*  buffered A fields.
- d_in_valid / d_in_ready  in/out  1/1  downstream D handshake.
- d_in_opcode, d_in_param, d_in_size, d_in_source  in  3/2/2/3  D control fields.
- d_in_denied, d_in_corrupt, d_in_data  in  1/1/32  D payload.
- d_out_valid / d_out_ready  out/in  1/1  upstream D handshake.
- d_out_*  out  same widths as d_in_*  buffered D fields.
- inflight  out  4  current outstanding-request count.
- protocol_err  out  1  sticky; set when a D response arrives while nothing is outstanding.

## Operation
- **Fire rule:** a transfer fires when valid && ready in the same cycle. A valid, once raised, holds and its fields stay stable until it fires; the block relies on this and does not check it.
- **A path:**
  - a_in_ready = !a_full && (inflight < MAX_INFLIGHT).
  - An a_in fire enqueues all A fields.
  - a_out_valid = !a_empty, and a_out_* shows the FIFO head.
  - An a_out fire dequeues.
- **D path:**
  - d_in_ready = !d_full.
  - A d_in fire enqueues; a d_out fire dequeues.
  - d_out_valid = !d_empty.
- **FIFO:** read and write pointers wrap modulo depth. An occupancy counter of width clog2(depth+1) drives full (count == depth) and empty (count == 0). A full FIFO deasserts ready even if a dequeue happens in the same cycle (no pipe-through). Enqueue and dequeue in the same cycle leave the count unchanged.
- **In-flight counter:**
  - +1 on an a_in fire; −1 on a d_out fire; both in one cycle leave it unchanged.
  - A d_out fire with inflight == 0 keeps the counter at 0 and sets protocol_err.
  - protocol_err clears only on reset.
- **No field inspection:** the block does not decode opcode or source; ordering is strict FIFO per channel.

## Timing
- **Reset:** while reset_n is low, all pointers, counts, inflight and protocol_err are 0. a_out_valid, d_out_valid, a_in_ready and d_in_ready are 0 (readies are gated by a registered reset-release flop). Data outputs are don't-care but must not be X-propagated into valid.
- **Reset release:** on the first rising edge after reset_n deasserts, the readies go to 1.
- **Mid-operation reset:** FIFO contents are discarded, the counters clear, and no partial transfer is emitted.
- **Latency:** A and D each have 1 cycle of latency (fire at edge N, out_valid at N+1); with flow mode, see Configuration.
- **Throughput:** one transfer per cycle per channel at steady state when depth ≥2 and the consumer is always ready.
- **Registered readies:** a_in_ready and d_in_ready depend only on registered state; they have no combinational path from a_out_ready or d_out_ready.

## Configuration
- **TL_LINK_BUF_FLOW_EN defined:**
  - When the A FIFO is empty and a_in_valid is high, a_in_* passes combinationally to a_out_*, with a_out_valid = a_in_valid.
  - If a_out_ready is also high the entry is not written (zero latency). Otherwise it is enqueued as normal.
  - The D path is unchanged.
- **Undefined:** strictly registered operation with 1-cycle latency, as above.

## Structure
- **Package tl_link_pkg:**
  - Width localparams: OPCODE_W 3, SOURCE_W 3, SIZE_W 2, ADDR_W 30, DATA_W 32, MASK_W 4.
  - TL-UL opcode constants: Get 4, PutFull 0, PutPartial 1, AccessAck 0, AccessAckData 1.
  - Packed struct typedefs tl_a_t and tl_d_t.
- **Sub-module tl_link_fifo:** parameterised on width and depth, with a flow option. It is instantiated once for A (packed tl_a_t) and once for D (packed tl_d_t). The top module holds the in-flight counter, protocol_err and the ready gating.

## Test plan
- **Single request:** one Get (source 5, address 0x1000) with a_out_ready=1 → a_out_valid 1 cycle later with identical fields; inflight=1. A D AccessAckData (data 0xDEADBEEF) returns → d_out shows it next cycle; inflight=0.
- **In-flight cap:** MAX_INFLIGHT=4 with the D side stalled and a_out_ready=1 → 4 requests accepted; a_in_ready drops after the 4th fire. One d_out fire → a_in_ready reasserts the next cycle.
- **Backpressure full/wrap:** a_out_ready=0, two enqueues → a_in_ready=0. Then 6 alternating enqueue/dequeue cycles → FIFO order preserved across pointer wrap and occupancy stays 1–2.
- **Spurious response:** a D response injected with inflight=0 → protocol_err=1 and stays 1; inflight stays 0; the response is still delivered on d_out.
- **Mid-burst reset:** reset_n pulsed low with 2 entries queued → valids and readies go to 0 asynchronously. After release: empty, inflight 0, protocol_err 0, readies 1 one cycle later.
- **Flow mode (TL_LINK_BUF_FLOW_EN):** empty FIFO, a_in_valid with a_out_ready=1 → a_out_valid in the same cycle with matching fields; FIFO count stays 0.
